// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt controller.
package intr_pkg;
  localparam int N_IRQ_DEF    = 8;
  localparam int MAX_NEST_DEF = 4;
  localparam logic [1:0] S_INC_INTR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    VECT = 2'd2
  } state_e;
endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-set-bit one-hot encoder; bit 0 is the highest priority.
module intr_prio_enc #(
  parameter int W = 8
) (
  input  logic [W-1:0] req_i,
  output logic [W-1:0] onehot_o,
  output logic         valid_o
);
  assign onehot_o = req_i & (~req_i + W'(1));
  assign valid_o  = |req_i;
endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-detected pending, fixed-priority nesting, one-cycle vector at instruction boundary.
// Optional INTC_SYNC_EN adds a 2-flop synchronizer on irq ahead of edge detection.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter  int N_IRQ    = N_IRQ_DEF,
  parameter  int MAX_NEST = MAX_NEST_DEF,
  localparam int DW       = $clog2(MAX_NEST + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             instr_end,
  input  logic             reti,
  input  logic             ei,
  input  logic             di,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wd,
  output logic [N_IRQ-1:0] intr,
  output logic             push,
  output logic             s_intr,
  output logic             take,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] in_service,
  output logic [DW-1:0]    depth
);
  // States: IDLE no winner | ARM winner held, waiting for instr_end | VECT one-cycle vector
  state_e           state_q, state_d;
  logic [N_IRQ-1:0] irq_s, irq_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] in_service_q, in_service_d;
  logic [N_IRQ-1:0] mask_q, win_q, win_d;
  logic             gie_q, gie_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [N_IRQ-1:0] rise, eligible, svc_oh, below_svc, cand, win_oh;
  logic             svc_valid, win_valid, vect, reti_ok;
  logic [1:0]       s_inc;

`ifdef INTC_SYNC_EN
  logic [N_IRQ-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
    end
  end
  assign irq_s = sync2_q;
`else
  assign irq_s = irq;
`endif

  assign rise     = irq_s & ~irq_q;
  assign eligible = (gie_q && (depth_q < DW'(MAX_NEST))) ? (pending_q & mask_q) : '0;

  intr_prio_enc #(.W(N_IRQ)) u_svc_enc (
    .req_i   (in_service_q),
    .onehot_o(svc_oh),
    .valid_o (svc_valid)
  );

  // Only levels strictly above the current in-service level may preempt.
  assign below_svc = svc_valid ? (svc_oh - N_IRQ'(1)) : '1;
  assign cand      = eligible & below_svc;

  intr_prio_enc #(.W(N_IRQ)) u_win_enc (
    .req_i   (cand),
    .onehot_o(win_oh),
    .valid_o (win_valid)
  );

  assign vect    = (state_q == VECT);
  assign reti_ok = instr_end & reti & ~vect & (depth_q != '0);

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    in_service_d = in_service_q;
    depth_d      = depth_q;
    gie_d        = gie_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          win_d   = win_oh;
          state_d = ARM;
        end
      end
      ARM: begin
        if (!win_valid) begin
          state_d = IDLE;
        end else begin
          win_d = win_oh;
          if (instr_end && !reti) state_d = VECT;
        end
      end
      VECT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    pending_d = (pending_q & ~(vect ? win_q : '0)) | rise;

    if (vect) begin
      in_service_d = in_service_q | win_q;
      depth_d      = depth_q + DW'(1);
    end else if (reti_ok) begin
      in_service_d = in_service_q & ~svc_oh;
      depth_d      = depth_q - DW'(1);
    end

    if (instr_end && di)      gie_d = 1'b0;
    else if (instr_end && ei) gie_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      irq_q        <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      mask_q       <= '0;
      win_q        <= '0;
      gie_q        <= 1'b0;
      depth_q      <= '0;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq_s;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      if (mask_we) mask_q <= mask_wd;
      win_q        <= win_d;
      gie_q        <= gie_d;
      depth_q      <= depth_d;
    end
  end

  // Vector outputs decode from state; reset masks them so no push escapes in the reset cycle.
  assign s_inc      = (vect && !reset) ? S_INC_INTR : 2'b00;
  assign take       = (s_inc == S_INC_INTR);
  assign push       = take;
  assign s_intr     = take;
  assign intr       = take ? win_q : '0;
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign depth      = depth_q;
endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus randomized run against a queue-based model.
module tb_intr_ctrl;
  localparam int N    = 8;
  localparam int MAXN = 4;

  logic       clk = 1'b0;
  logic       reset, instr_end, reti, ei, di, mask_we;
  logic [7:0] irq, mask_wd;
  logic [7:0] intr, pending, in_service;
  logic       push, s_intr, take;
  logic [2:0] depth;

  int errors = 0;
  int checks = 0;

  // Reference model: in-service levels kept as a stack of indices (newest = highest priority).
  logic [7:0] m_pend, m_mask, m_prev;
  bit         m_gie, m_armed, m_vect;
  int         m_winr;
  int         stk[$];

  always #5 clk = ~clk;

  intr_ctrl dut (
    .clk(clk), .reset(reset), .irq(irq), .instr_end(instr_end), .reti(reti),
    .ei(ei), .di(di), .mask_we(mask_we), .mask_wd(mask_wd), .intr(intr),
    .push(push), .s_intr(s_intr), .take(take), .pending(pending),
    .in_service(in_service), .depth(depth)
  );

  function automatic logic [7:0] m_svc();
    logic [7:0] r = 8'h00;
    foreach (stk[i]) r[stk[i]] = 1'b1;
    return r;
  endfunction

  task automatic step();
    int win, lim;
    logic [7:0] np;
    if (reset) begin
      m_pend = 0; m_mask = 0; m_prev = 0; m_gie = 0;
      m_armed = 0; m_vect = 0; m_winr = 0; stk.delete();
    end else begin
      win = -1;
      if (m_gie && stk.size() < MAXN) begin
        lim = (stk.size() == 0) ? N : stk[stk.size()-1];
        for (int i = 0; i < lim; i++)
          if (m_pend[i] && m_mask[i]) begin win = i; break; end
      end
      np = m_pend;
      if (m_vect) np[m_winr] = 1'b0;
      np = np | (irq & ~m_prev);
      if (m_vect) stk.push_back(m_winr);
      else if (instr_end && reti && stk.size() > 0) void'(stk.pop_back());
      if (instr_end && di) m_gie = 0;
      else if (instr_end && ei) m_gie = 1;
      if (mask_we) m_mask = mask_wd;
      if (m_vect) begin
        m_vect = 0; m_armed = 0;
      end else if (!m_armed) begin
        if (win >= 0) begin m_armed = 1; m_winr = win; end
      end else if (win < 0) begin
        m_armed = 0;
      end else begin
        m_winr = win;
        if (instr_end && !reti) begin m_armed = 0; m_vect = 1; end
      end
      m_pend = np;
      m_prev = irq;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    instr_end = 0; reti = 0; ei = 0; di = 0; mask_we = 0;
  endtask

  task automatic pulse_irq(input int b);
    irq = irq | (8'(1) << b);
    step();
    irq = irq & ~(8'(1) << b);
  endtask

  task automatic do_reti();
    clr(); instr_end = 1; reti = 1; step(); clr();
  endtask

  task automatic run_until_push(input int maxc, output logic [7:0] vec, output bit seen, output int n);
    seen = 0; vec = 0; n = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      step(); n++;
      if (push) begin seen = 1; vec = intr; end
    end
  endtask

  task automatic count_push(input int cyc, output int np);
    np = 0;
    repeat (cyc) begin step(); if (push) np++; end
  endtask

  task automatic test_reset();
    reset = 1; clr(); irq = 0; mask_wd = 0;
    step(); step();
    checks++; if (push !== 1'b0 || intr !== 8'h00 || take !== 1'b0) begin errors++; $display("FAIL reset_out: push=%b intr=%h take=%b want 0", push, intr, take); end
    reset = 0; step();
    checks++; if (pending !== 8'h00 || in_service !== 8'h00 || depth !== 3'd0) begin errors++; $display("FAIL reset_regs: pend=%h svc=%h depth=%0d want 0", pending, in_service, depth); end
  endtask

  task automatic test_single();
    logic [7:0] v; bit s; int n;
    clr(); mask_we = 1; mask_wd = 8'hFF; instr_end = 1; ei = 1; step(); clr();
    pulse_irq(3);
    checks++; if (pending !== 8'h08) begin errors++; $display("FAIL single_pend: got %h want 08", pending); end
    instr_end = 1;
    run_until_push(6, v, s, n);
    checks++; if (!s || v !== 8'h08 || n != 2) begin errors++; $display("FAIL single_vec: got %h seen=%0d n=%0d want 08 n=2", v, s, n); end
    checks++; if (s_intr !== 1'b1 || take !== 1'b1) begin errors++; $display("FAIL single_ctl: s_intr=%b take=%b want 1", s_intr, take); end
    clr(); step();
    checks++; if (push !== 1'b0 || in_service !== 8'h08 || depth !== 3'd1 || pending !== 8'h00) begin errors++; $display("FAIL single_after: push=%b svc=%h depth=%0d pend=%h", push, in_service, depth, pending); end
    do_reti();
    checks++; if (in_service !== 8'h00 || depth !== 3'd0) begin errors++; $display("FAIL single_reti: svc=%h depth=%0d want 0", in_service, depth); end
  endtask

  task automatic test_priority();
    logic [7:0] v; bit s; int n, np;
    clr(); irq = 8'h22; step(); irq = 0;
    instr_end = 1; run_until_push(6, v, s, n);
    checks++; if (!s || v !== 8'h02) begin errors++; $display("FAIL prio_first: got %h want 02", v); end
    count_push(4, np);
    checks++; if (np != 0 || pending !== 8'h20) begin errors++; $display("FAIL prio_hold: pushes=%0d pend=%h want 0,20", np, pending); end
    do_reti(); instr_end = 1; run_until_push(6, v, s, n);
    checks++; if (!s || v !== 8'h20) begin errors++; $display("FAIL prio_second: got %h want 20", v); end
    clr(); step(); do_reti();
    checks++; if (depth !== 3'd0 || in_service !== 8'h00) begin errors++; $display("FAIL prio_depth: depth=%0d svc=%h want 0", depth, in_service); end
  endtask

  task automatic test_nesting();
    logic [7:0] v; bit s; int n, np;
    clr(); pulse_irq(4); instr_end = 1; run_until_push(6, v, s, n);
    checks++; if (!s || v !== 8'h10) begin errors++; $display("FAIL nest_first: got %h want 10", v); end
    pulse_irq(2); run_until_push(6, v, s, n);
    checks++; if (!s || v !== 8'h04) begin errors++; $display("FAIL nest_preempt: got %h want 04", v); end
    step();
    checks++; if (depth !== 3'd2 || in_service !== 8'h14) begin errors++; $display("FAIL nest_depth: depth=%0d svc=%h want 2,14", depth, in_service); end
    pulse_irq(6); count_push(6, np);
    checks++; if (np != 0) begin errors++; $display("FAIL nest_block6: pushes=%0d want 0", np); end
    do_reti();
    checks++; if (in_service !== 8'h10 || depth !== 3'd1) begin errors++; $display("FAIL nest_reti1: svc=%h depth=%0d want 10,1", in_service, depth); end
    instr_end = 1; count_push(4, np);
    checks++; if (np != 0) begin errors++; $display("FAIL nest_block6b: pushes=%0d want 0", np); end
    do_reti(); instr_end = 1; run_until_push(6, v, s, n);
    checks++; if (!s || v !== 8'h40) begin errors++; $display("FAIL nest_late6: got %h want 40", v); end
    clr(); step(); do_reti();
  endtask

  task automatic test_mask_gie();
    logic [7:0] v; bit s; int n, np;
    clr(); mask_we = 1; mask_wd = 8'hFE; step(); clr();
    pulse_irq(0); instr_end = 1; count_push(5, np);
    checks++; if (np != 0 || pending[0] !== 1'b1) begin errors++; $display("FAIL mask_block: pushes=%0d pend=%h want 0,01", np, pending); end
    clr(); mask_we = 1; mask_wd = 8'hFF; step(); clr();
    instr_end = 1; run_until_push(6, v, s, n);
    checks++; if (!s || v !== 8'h01) begin errors++; $display("FAIL mask_open: got %h want 01", v); end
    clr(); step(); do_reti();
    instr_end = 1; di = 1; step(); clr();
    pulse_irq(2); instr_end = 1; count_push(5, np);
    checks++; if (np != 0 || pending[2] !== 1'b1) begin errors++; $display("FAIL gie_block: pushes=%0d pend=%h want 0,04", np, pending); end
    ei = 1; step(); ei = 0; run_until_push(6, v, s, n);
    checks++; if (!s || v !== 8'h04) begin errors++; $display("FAIL gie_open: got %h want 04", v); end
    clr(); step(); do_reti();
  endtask

  task automatic test_depth_limit();
    logic [7:0] v; bit s; int n, np;
    for (int b = 7; b >= 4; b--) begin
      clr(); pulse_irq(b); instr_end = 1; run_until_push(6, v, s, n);
      checks++; if (!s || v !== (8'(1) << b)) begin errors++; $display("FAIL depth_vec%0d: got %h seen=%0d", b, v, s); end
      clr(); step();
    end
    checks++; if (depth !== 3'd4 || in_service !== 8'hF0) begin errors++; $display("FAIL depth_full: depth=%0d svc=%h want 4,F0", depth, in_service); end
    pulse_irq(3); instr_end = 1; count_push(6, np);
    checks++; if (np != 0 || pending[3] !== 1'b1) begin errors++; $display("FAIL depth_block: pushes=%0d pend=%h want 0,08", np, pending); end
    do_reti();
    checks++; if (depth !== 3'd3) begin errors++; $display("FAIL depth_reti: depth=%0d want 3", depth); end
    instr_end = 1; run_until_push(6, v, s, n);
    checks++; if (!s || v !== 8'h08) begin errors++; $display("FAIL depth_late3: got %h want 08", v); end
    clr(); step();
    repeat (4) do_reti();
    checks++; if (depth !== 3'd0 || in_service !== 8'h00) begin errors++; $display("FAIL depth_drain: depth=%0d svc=%h want 0", depth, in_service); end
  endtask

  task automatic test_reti_underflow();
    do_reti();
    checks++; if (depth !== 3'd0 || in_service !== 8'h00 || pending !== 8'h00) begin errors++; $display("FAIL reti_underflow: depth=%0d svc=%h pend=%h want 0", depth, in_service, pending); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] v; bit s; int n;
    clr(); pulse_irq(1); step();
    checks++; if (push !== 1'b0 || pending !== 8'h02) begin errors++; $display("FAIL arm_pre: push=%b pend=%h want 0,02", push, pending); end
    reset = 1; instr_end = 1; step();
    checks++; if (intr !== 8'h00 || push !== 1'b0 || s_intr !== 1'b0 || take !== 1'b0 || pending !== 8'h00) begin errors++; $display("FAIL arm_reset: intr=%h push=%b pend=%h want 0", intr, push, pending); end
    reset = 0; clr(); step();
    mask_we = 1; mask_wd = 8'hFF; instr_end = 1; ei = 1; step(); clr();
    pulse_irq(6); instr_end = 1; run_until_push(6, v, s, n);
    checks++; if (!s || v !== 8'h40) begin errors++; $display("FAIL vect_pre: got %h want 40", v); end
    reset = 1; #1;
    checks++; if (push !== 1'b0 || take !== 1'b0) begin errors++; $display("FAIL vect_reset: push=%b take=%b want 0", push, take); end
    step(); reset = 0; clr(); step();
    checks++; if (in_service !== 8'h00 || depth !== 3'd0) begin errors++; $display("FAIL vect_abort: svc=%h depth=%0d want 0", in_service, depth); end
  endtask

  task automatic test_random();
    logic [7:0] ei_exp;
    reset = 1; clr(); irq = 0; step(); reset = 0; step();
    for (int c = 0; c < 800; c++) begin
      instr_end = 1'($urandom_range(0, 1));
      reti      = instr_end && ($urandom_range(0, 4) == 0);
      ei        = instr_end && ($urandom_range(0, 5) == 0);
      di        = instr_end && ($urandom_range(0, 15) == 0);
      mask_we   = ($urandom_range(0, 19) == 0);
      mask_wd   = 8'($urandom) | 8'($urandom);
      if ($urandom_range(0, 2) == 0) irq = irq ^ (8'(1) << $urandom_range(0, 7));
      reset     = ($urandom_range(0, 299) == 0);
      step();
      ei_exp = m_vect ? (8'(1) << m_winr) : 8'h00;
      checks++; if (intr !== ei_exp) begin errors++; $display("FAIL rnd_intr c=%0d: got %h want %h", c, intr, ei_exp); end
      checks++; if (push !== m_vect || take !== m_vect || s_intr !== m_vect) begin errors++; $display("FAIL rnd_push c=%0d: got %b want %b", c, push, m_vect); end
      checks++; if (pending !== m_pend) begin errors++; $display("FAIL rnd_pend c=%0d: got %h want %h", c, pending, m_pend); end
      checks++; if (in_service !== m_svc()) begin errors++; $display("FAIL rnd_svc c=%0d: got %h want %h", c, in_service, m_svc()); end
      checks++; if (depth !== 3'(stk.size())) begin errors++; $display("FAIL rnd_depth c=%0d: got %0d want %0d", c, depth, stk.size()); end
    end
    reset = 0; clr();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1; irq = 0; mask_wd = 0; clr();
    test_reset();
    test_single();
    test_priority();
    test_nesting();
    test_mask_gie();
    test_depth_limit();
    test_reti_underflow();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
